// File: rtl/requant_pipeline_pkg.sv
// Shared NPU requantization definitions: out_mode encodings, table field widths
// and the shift-limit helper used when a channel entry is written.
package requant_pipeline_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int SHIFT_W     = 6;

  typedef enum logic [1:0] {
    QMODE_INT8     = 2'd0,
    QMODE_INT16    = 2'd1,
    QMODE_FULL     = 2'd2,
    QMODE_FULL_ALT = 2'd3
  } qmode_e;

  typedef struct packed {
    logic signed [SCALE_WIDTH-1:0] scale;
    logic        [SHIFT_W-1:0]     shift;
    logic signed [DATA_WIDTH-1:0]  zp;
  } ch_entry_t;

  // Largest useful right shift: beyond this the rounded product is always 0 or -1.
  function automatic int shift_limit(input int data_w, input int scale_w);
    return data_w + scale_w - 2;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational clamp of the widened requantized value to the range selected
// by out_mode; the saturation flag exists only when REQUANT_STATS_EN is defined.
module requant_sat #(
  parameter int DATA_WIDTH = 32,
  parameter int RW         = 49
) (
  input  logic signed [RW-1:0]         i_r,
  input  logic        [1:0]            i_mode,
`ifdef REQUANT_STATS_EN
  output logic                         o_sat,
`endif
  output logic signed [DATA_WIDTH-1:0] o_data
);
  import requant_pipeline_pkg::*;

  logic signed [DATA_WIDTH-1:0] w_max;
  logic signed [DATA_WIDTH-1:0] w_min;
  logic signed [RW-1:0]         w_max_ext;
  logic signed [RW-1:0]         w_min_ext;
  logic                         w_over;
  logic                         w_under;

  // Two's complement bounds are symmetric under inversion: min = ~max.
  always_comb begin
    w_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    case (i_mode)
      QMODE_INT8:  w_max = DATA_WIDTH'(127);
      QMODE_INT16: w_max = DATA_WIDTH'(32767);
      default:     w_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endcase
    w_min = ~w_max;
  end

  assign w_max_ext = {{(RW-DATA_WIDTH){w_max[DATA_WIDTH-1]}}, w_max};
  assign w_min_ext = {{(RW-DATA_WIDTH){w_min[DATA_WIDTH-1]}}, w_min};
  assign w_over    = i_r > w_max_ext;
  assign w_under   = i_r < w_min_ext;

  assign o_data = w_over  ? w_max :
                  w_under ? w_min : i_r[DATA_WIDTH-1:0];

`ifdef REQUANT_STATS_EN
  assign o_sat = w_over | w_under;
`endif

endmodule

// File: rtl/requant_pipeline.sv
// Three-stage per-channel requantizer (scale, round-shift, offset, saturate) with
// a global valid/ready stall. Define REQUANT_STATS_EN to add the sat_count port.
module requant_pipeline #(
  parameter int DATA_WIDTH  = requant_pipeline_pkg::DATA_WIDTH,
  parameter int SCALE_WIDTH = requant_pipeline_pkg::SCALE_WIDTH,
  parameter int NUM_CH      = 16,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int SHIFT_W     = requant_pipeline_pkg::SHIFT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic [DATA_WIDTH-1:0]  cfg_zp,
  input  logic [1:0]             out_mode,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CH_W-1:0]        in_ch,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef REQUANT_STATS_EN
  output logic [31:0]            sat_count,
`endif
  output logic                   busy
);
  import requant_pipeline_pkg::*;

  localparam int PW        = DATA_WIDTH + SCALE_WIDTH;
  localparam int RW        = PW + 1;
  localparam int SHIFT_MAX = shift_limit(DATA_WIDTH, SCALE_WIDTH);

  typedef struct packed {
    logic signed [SCALE_WIDTH-1:0] scale;
    logic        [SHIFT_W-1:0]     shift;
    logic signed [DATA_WIDTH-1:0]  zp;
  } entry_t;

  entry_t r_table [NUM_CH];

  logic                         w_en;
  entry_t                       w_entry;
  logic        [SHIFT_W-1:0]    w_cfg_shift;
  logic signed [PW-1:0]         w_in_ext;
  logic signed [PW-1:0]         w_scale_ext;
  logic signed [PW-1:0]         w_prod;

  logic                         r_v1;
  logic signed [PW-1:0]         r_prod1;
  logic        [SHIFT_W-1:0]    r_shift1;
  logic signed [DATA_WIDTH-1:0] r_zp1;
  logic        [1:0]            r_mode1;

  logic signed [RW-1:0]         w_prod_ext;
  logic signed [RW-1:0]         w_rnd;
  logic signed [RW-1:0]         w_sum;
  logic signed [RW-1:0]         w_shr;
  logic signed [RW-1:0]         w_zp_ext;
  logic signed [RW-1:0]         w_r;

  logic                         r_v2;
  logic signed [RW-1:0]         r_r2;
  logic        [1:0]            r_mode2;

  logic signed [DATA_WIDTH-1:0] w_clamped;
  logic                         r_v3;
  logic        [DATA_WIDTH-1:0] r_data3;

  // One enable for every stage: the pipe only moves when the output can drain.
  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  assign w_cfg_shift = (int'(cfg_shift) > SHIFT_MAX) ? SHIFT_W'(SHIFT_MAX) : cfg_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_table[i] <= '{scale: SCALE_WIDTH'(1), shift: '0, zp: '0};
      end
    end else if (cfg_we) begin
      r_table[cfg_ch] <= '{scale: cfg_scale, shift: w_cfg_shift, zp: cfg_zp};
    end
  end

  // The lookup reads the pre-edge table, so a same-cycle write is seen only by later beats.
  assign w_entry     = r_table[in_ch];
  assign w_in_ext    = {{SCALE_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
  assign w_scale_ext = {{DATA_WIDTH{w_entry.scale[SCALE_WIDTH-1]}}, w_entry.scale};
  assign w_prod      = w_in_ext * w_scale_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_prod1  <= '0;
      r_shift1 <= '0;
      r_zp1    <= '0;
      r_mode1  <= '0;
    end else if (w_en) begin
      r_v1     <= in_valid;
      r_prod1  <= w_prod;
      r_shift1 <= w_entry.shift;
      r_zp1    <= w_entry.zp;
      r_mode1  <= out_mode;
    end
  end

  assign w_prod_ext = {r_prod1[PW-1], r_prod1};
  assign w_rnd      = (r_shift1 != '0) ? (RW'(1) << (r_shift1 - SHIFT_W'(1))) : '0;
  assign w_sum      = w_prod_ext + w_rnd;
  assign w_shr      = w_sum >>> r_shift1;
  assign w_zp_ext   = {{(RW-DATA_WIDTH){r_zp1[DATA_WIDTH-1]}}, r_zp1};
  assign w_r        = w_shr + w_zp_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_r2    <= '0;
      r_mode2 <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_r2    <= w_r;
      r_mode2 <= r_mode1;
    end
  end

`ifdef REQUANT_STATS_EN
  logic w_sat;
  logic r_sat3;
  logic [31:0] r_sat_count;

  requant_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .RW         (RW)
  ) u_sat (
    .i_r    (r_r2),
    .i_mode (r_mode2),
    .o_sat  (w_sat),
    .o_data (w_clamped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat3 <= 1'b0;
    end else if (w_en) begin
      r_sat3 <= w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (r_v3 && out_ready && r_sat3) begin
      r_sat_count <= r_sat_count + 32'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  requant_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .RW         (RW)
  ) u_sat (
    .i_r    (r_r2),
    .i_mode (r_mode2),
    .o_data (w_clamped)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r_data3 <= '0;
    end else if (w_en) begin
      r_v3    <= r_v2;
      r_data3 <= w_clamped;
    end
  end

  assign out_valid = r_v3;
  assign out_data  = r_data3;
  assign busy      = r_v1 | r_v2 | r_v3;

endmodule

// File: tb/tb_requant_pipeline.sv
// Directed, table-driven bench for requant_pipeline plus stall, same-cycle
// config write and mid-stream reset sequences. Honors REQUANT_STATS_EN.
module tb_requant_pipeline;

  localparam int DW  = 32;
  localparam int SW  = 16;
  localparam int NCH = 16;
  localparam int CW  = 4;
  localparam int SHW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [SW-1:0] cfg_scale;
  logic [SHW-1:0] cfg_shift;
  logic [DW-1:0] cfg_zp;
  logic [1:0]    out_mode;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ch;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef REQUANT_STATS_EN
  logic [31:0]   sat_count;
`endif

  always #5 clk = ~clk;

  requant_pipeline #(
    .DATA_WIDTH  (DW),
    .SCALE_WIDTH (SW),
    .NUM_CH      (NCH),
    .CH_W        (CW),
    .SHIFT_W     (SHW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .out_mode  (out_mode),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef REQUANT_STATS_EN
    .sat_count (sat_count),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic [1:0]    mode;
    logic [DW-1:0] expected;
    bit            sat;
    string         name;
  } vec_t;

  vec_t vecs [13];
  int   nChecks = 0;
  int   nFails  = 0;
  int   expSat  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic cfgWrite(input logic [CW-1:0] ch, input logic [SW-1:0] scale,
                          input logic [SHW-1:0] shift, input logic [DW-1:0] zp);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_scale = scale; cfg_shift = shift; cfg_zp = zp;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents one beat for a single rising edge; caller keeps out_ready high.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic [CW-1:0] ch, input logic [1:0] mode);
    in_valid = 1'b1; in_data = data; in_ch = ch; out_mode = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits a bounded number of cycles for out_valid; lat counts the idle samples.
  task automatic waitOutput(input string name, input logic [DW-1:0] exp, output int lat);
    bit found = 1'b0;
    lat = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else lat++;
    end
    checkOutput({name, "_valid"}, 32'(found), 32'd1);
    if (found) checkOutput(name, out_data, exp);
  endtask

  initial begin
    int lat;
    int got;
    int sent;
    int stallCycles;
    int stale;

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0;
    out_mode = 2'd2; in_data = '0; in_ch = '0; in_valid = 1'b0; out_ready = 1'b1;

    vecs[0]  = '{32'd100,        4'd0, 2'd2, 32'd100,        1'b0, "ident_full"};
    vecs[1]  = '{32'd7,          4'd3, 2'd2, 32'd16,         1'b0, "ch3_pos"};
    vecs[2]  = '{32'hFFFF_FFF9,  4'd3, 2'd2, 32'hFFFF_FFFB,  1'b0, "ch3_neg_round"};
    vecs[3]  = '{32'd1000,       4'd0, 2'd0, 32'd127,        1'b1, "int8_hi_sat"};
    vecs[4]  = '{32'hFFFF_FC18,  4'd0, 2'd0, 32'hFFFF_FF80,  1'b1, "int8_lo_sat"};
    vecs[5]  = '{32'd127,        4'd0, 2'd0, 32'd127,        1'b0, "int8_edge"};
    vecs[6]  = '{32'd40000,      4'd0, 2'd1, 32'd32767,      1'b1, "int16_hi_sat"};
    vecs[7]  = '{32'hFFFF_8000,  4'd0, 2'd1, 32'hFFFF_8000,  1'b0, "int16_lo_edge"};
    vecs[8]  = '{32'd5,          4'd4, 2'd2, 32'hFFFF_FFFB,  1'b0, "ch4_negscale"};
    vecs[9]  = '{32'h7FFF_FFFF,  4'd5, 2'd3, 32'h7FFF_FFFF,  1'b1, "full_hi_sat"};
    vecs[10] = '{32'h8000_0000,  4'd5, 2'd2, 32'h8000_0000,  1'b1, "full_lo_sat"};
    vecs[11] = '{32'hFFFF_FF9C,  4'd6, 2'd2, 32'd7,          1'b0, "shift_clamp"};
    vecs[12] = '{32'd0,          4'd7, 2'd0, 32'd127,        1'b1, "zp_then_sat"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef REQUANT_STATS_EN
    checkOutput("reset_sat_count", sat_count, 32'd0);
`endif

    cfgWrite(4'd3, 16'd3, 6'd1, 32'd5);
    cfgWrite(4'd4, 16'hFFFE, 6'd2, 32'hFFFF_FFFD);
    cfgWrite(4'd5, 16'd2, 6'd0, 32'd0);
    cfgWrite(4'd6, 16'd1, 6'd63, 32'd7);
    cfgWrite(4'd7, 16'd1, 6'd0, 32'd200);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].data, vecs[i].ch, vecs[i].mode);
      waitOutput(vecs[i].name, vecs[i].expected, lat);
      checkOutput({vecs[i].name, "_latency"}, 32'(lat + 1), 32'd3);
      if (vecs[i].sat) expSat++;
    end
    @(negedge clk);
    checkOutput("vectors_drained_busy", 32'(busy), 32'd0);
`ifdef REQUANT_STATS_EN
    checkOutput("sat_count_vectors", sat_count, 32'(expSat));
`endif

    // Ten back-to-back beats with out_ready held low for five cycles.
    got = 0; sent = 0; stallCycles = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 10) begin
        in_valid = 1'b1; in_data = 32'((sent + 1) * 3); in_ch = 4'd0; out_mode = 2'd2;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stallCycles++;
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("stream_beat%0d", got), out_data, 32'((got + 1) * 3));
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", 32'(got), 32'd10);
    checkOutput("stream_stall_cycles", 32'(stallCycles), 32'd5);
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("stream_no_extra", 32'(stale), 32'd0);

    // Table write and beat to the same channel in one cycle.
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 4'd2; cfg_scale = 16'd2; cfg_shift = 6'd0; cfg_zp = 32'd0;
    in_valid = 1'b1; in_data = 32'd9; in_ch = 4'd2; out_mode = 2'd2;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    waitOutput("wr_same_cycle", 32'd9, lat);
    applyStimulus(32'd9, 4'd2, 2'd2);
    waitOutput("wr_next_beat", 32'd18, lat);

    // Reset with three beats in flight.
    @(negedge clk);
    applyStimulus(32'd50, 4'd5, 2'd2);
    applyStimulus(32'd51, 4'd5, 2'd2);
    applyStimulus(32'd52, 4'd5, 2'd2);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
`ifdef REQUANT_STATS_EN
    checkOutput("post_reset_sat_count", sat_count, 32'd0);
`endif
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("post_reset_no_stale", 32'(stale), 32'd0);
    applyStimulus(32'd50, 4'd5, 2'd2);
    waitOutput("post_reset_ch5_identity", 32'd50, lat);
    applyStimulus(32'd7, 4'd3, 2'd2);
    waitOutput("post_reset_ch3_identity", 32'd7, lat);
    applyStimulus(32'd1000, 4'd7, 2'd0);
    waitOutput("post_reset_ch7_identity", 32'd127, lat);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/requant_pipeline.md
# requant_pipeline

Per-channel requantization pipeline for the NPU datapath. Takes signed accumulator results tagged with an output-channel index, then applies a per-channel scale multiply, a rounding right-shift and a zero-point offset, and saturates the result to a run-time-selected integer width. It sits between the MAC array drain and activation/writeback. It is the fully pipelined, multi-channel, saturating successor to the single-beat quantization unit, and it accepts one beat per cycle under valid/ready backpressure.

## Interface
- DATA_WIDTH, 32 — input accumulator and output word width (signed)
- SCALE_WIDTH, 16 — per-channel signed scale width
- NUM_CH, 16 — channel table depth (power of two, ≥2)
- CH_W, $clog2(NUM_CH) — channel index width
- SHIFT_W, 6 — per-channel shift field width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  write the channel table entry
- cfg_ch  in  CH_W  table entry to write
- cfg_scale  in  SCALE_WIDTH  signed scale
- cfg_shift  in  SHIFT_W  right-shift amount; values > DATA_WIDTH+SCALE_WIDTH-2 are clamped to that limit
- cfg_zp  in  DATA_WIDTH  signed zero point
- out_mode  in  2  0 = int8, 1 = int16, 2 or 3 = full DATA_WIDTH
- in_data  in  DATA_WIDTH  signed accumulator value
- in_ch  in  CH_W  channel of the in_data beat
- in_valid / in_ready  in / out  1  input handshake
- out_data  out  DATA_WIDTH  result, sign-extended to DATA_WIDTH
- out_valid / out_ready  out / in  1  output handshake
- busy  out  1  any pipeline stage holds a valid beat
- sat_count  out  32  saturation event count (only with REQUANT_STATS_EN)

## Operation
- Channel table: NUM_CH registered entries of {scale, shift, zp}.
  - Reset value is identity: scale=1, shift=0, zp=0.
  - A write lands at the clock edge where cfg_we=1.
- Stage 1 (S1): on acceptance (in_valid && in_ready):
  - Look up the table entry for in_ch.
  - Register the product = in_data × scale at full width (DATA_WIDTH+SCALE_WIDTH bits, signed).
  - Register shift, zp and out_mode with the beat.
- Stage 2 (S2): round-half-up, then arithmetic shift and offset.
  - Rounding: if shift>0, add 1<<(shift-1) before the shift. If shift=0, pass the product unchanged.
  - Compute r = (product + rnd) >>> shift, then add zp sign-extended. Keep r at width DATA_WIDTH+SCALE_WIDTH+1, so no intermediate overflow occurs.
- Stage 3 (S3): clamp r to the range for the beat's out_mode.
  - int8: [-128, 127]
  - int16: [-32768, 32767]
  - full: [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
  - Register the clamped value as out_data, sign-extended.
  - A beat is saturated when the clamp changes its value.
- Parameters are captured per beat at S1. Table writes or out_mode changes never alter beats already in flight.
- A table write to the same channel in the same cycle that channel's beat is accepted: the beat uses the old entry.

## Timing
- Latency: 3 cycles from acceptance to out_valid, with no stalls.
- Throughput: 1 beat/cycle.
- Global stall: in_ready = !out_valid || out_ready.
  - When in_ready=0, all three stages hold.
  - Stage valids advance only when the pipe is enabled.
  - Bubbles are not compressed (no per-stage ready).
- While stalled, out_data and out_valid are stable. Once asserted, out_valid stays high until out_ready.
- Order is preserved. No beat is dropped or duplicated.
- Reset values: out_valid=0, out_data=0, busy=0, sat_count=0, all stage valids=0, table=identity, in_ready=1 (follows from out_valid=0).
- rst asserted mid-stream: in-flight beats are discarded and the table returns to identity on the next edge.
- busy = OR of S1, S2 and S3 valids.

## Configuration
- REQUANT_STATS_EN defined:
  - sat_count port exists.
  - It increments by 1 per saturated beat at the S3 output handshake (out_valid && out_ready) and wraps at 2^32.
  - It clears on rst.
- REQUANT_STATS_EN undefined: sat_count port and counter are absent, and the saturation-detect logic is removed.

## Structure
- The shared NPU definitions package holds:
  - the out_mode encodings (QMODE_INT8, QMODE_INT16, QMODE_FULL)
  - the table-entry struct/field widths
  - DATA_WIDTH.
- One sub-module, requant_sat: a combinational clamp taking r and out_mode, producing the clamped value and a sat flag. It is instantiated in S3.

## Test plan
- Identity reset table, out_mode=2, in_data=100 ch0 → out_data=100, out_valid exactly 3 cycles after acceptance.
- ch3 = {scale=3, shift=1, zp=5}: in_data=7 → 16; in_data=-7 → -5 (checks rounding on a negative value).
- out_mode=0, identity entry: in_data=1000 → 127; in_data=-1000 → -128; sat_count=2 (with REQUANT_STATS_EN).
- Continuous input of 10 beats with out_ready low for 5 cycles mid-stream:
  - in_ready drops the cycle out_valid is held.
  - All 10 beats emerge in order and unchanged.
- cfg_we to ch2 (scale=2) in the same cycle a ch2 beat with in_data=9 is accepted → that beat gives 9; the next ch2 beat with 9 gives 18.
- rst pulsed with 3 beats in flight → out_valid=0 and busy=0 next cycle, no stale beats appear, and the table is back to identity.
